clock_mode_ctrl: RTL
====================

// Module: clock_mode_ctrl
// PURPOSE
//  Sequencer for the MM:SS counter's single increment input (insignal).
//  Three modes: RUN, SET_MIN, SET_SEC.
//  - RUN: produces a 1 Hz count pulse from a prescaler.
//  - SET_SEC: each inc button press gives one pulse (seconds +1).
//  - SET_MIN: each press gives a 60-pulse burst (minutes +1, seconds kept).
//  Also drives blink/blank enables for the 7-seg display driver.
// PARAMETERS
//  DIV        100_000_000  clk cycles per count tick in RUN (1 Hz at 100 MHz)
//  BLINK_DIV  25_000_000   clk cycles per blink-phase toggle in set modes
//  BURST_LEN  60           pulses per SET_MIN press (seconds per minute)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  async, active-low reset
//  btn_mode     in   1  1-cycle pulse (debounced, edge-detected upstream): next mode
//  btn_inc      in   1  1-cycle pulse (debounced, edge-detected upstream): increment
//  count_pulse  out  1  drives counter insignal; high exactly 1 cycle per increment
//  mode         out  2  00 RUN, 01 SET_MIN, 10 SET_SEC (11 never driven)
//  busy         out  1  high while a SET_MIN burst is in progress
//  blank_min    out  1  high = display blanks minute digits (blink off-phase)
//  blank_sec    out  1  high = display blanks second digits (blink off-phase)
// BEHAVIOUR
//  Clock is clk; reset is asynchronous, active-low (reset=0 clears all state).
//  Reset values: state=RUN; prescaler, burst count, blink count and blink phase = 0.
//  Outputs at reset: count_pulse=0, mode=00, busy=0, blank_min=0, blank_sec=0.
//  States: RUN, SET_MIN, BURST, SET_SEC.
//  - RUN: prescaler counts 0..DIV-1.
//    - count_pulse=1 in the cycle the prescaler equals DIV-1; prescaler then wraps to 0.
//    - btn_mode -> SET_MIN. btn_inc ignored.
//  - SET_MIN:
//    - btn_inc -> BURST with burst count=0.
//    - btn_mode -> SET_SEC.
//    - btn_inc and btn_mode in the same cycle: btn_mode wins; no burst.
//  - BURST:
//    - count_pulse=1 on every cycle, BURST_LEN consecutive cycles.
//    - busy=1 throughout; burst count increments each cycle.
//    - After the pulse with burst count == BURST_LEN-1, return to SET_MIN.
//    - btn_mode and btn_inc ignored (dropped, not queued) while in BURST.
//  - SET_SEC:
//    - btn_inc -> count_pulse=1 on the next cycle (registered, 1-cycle latency).
//    - btn_mode -> RUN.
//    - btn_inc and btn_mode in the same cycle: btn_mode wins; no pulse.
//  - Latency: every count_pulse is a registered output, asserted 1 cycle after
//    the enabling condition.
//  - Prescaler in set modes:
//    - Held at 0 in SET_MIN, BURST and SET_SEC, so time does not advance.
//    - On entry to RUN it restarts from 0; first RUN pulse comes DIV cycles after entry.
//  - Blink:
//    - In SET_MIN/BURST/SET_SEC, the blink counter counts 0..BLINK_DIV-1 and
//      toggles the blink phase on wrap.
//    - blank_min = phase & (state in SET_MIN or BURST); blank_sec = phase & (state == SET_SEC).
//    - In RUN, blink counter and phase are cleared to 0.
//    - Blink counter and phase are cleared on every mode change, so each new
//      mode starts with digits visible.
//  - Widths: prescaler and blink counter are $clog2(parameter) bits;
//    burst count is $clog2(BURST_LEN+1) bits. No overflow is reachable.
//  - Reset mid-burst: burst aborts immediately; outputs take reset values.
//    Pulses already issued stay applied in the counter unless the counter is
//    reset too (shared reset).
//  - mode=11 is unreachable; an illegal state recovers to RUN.
// STRUCTURE
//  Shared package clock_pkg:
//  - typedef enum logic [1:0] {RUN=2'b00, SET_MIN=2'b01, SET_SEC=2'b10} mode_t
//    (mode output encoding; BURST is internal and reports mode=01).
//  - SECS_PER_MIN=60 (also used by the counter).
//  One sub-module: tick_prescaler.
//  - Generic modulo-N counter with enable and sync clear; 1-cycle pulse on wrap.
//  - Instantiated twice: DIV for the run tick, BLINK_DIV for the blink phase.
//  FSM, burst counter and output registers are in this module.
// TESTING (sim with DIV=10, BLINK_DIV=4)
//  1. Release reset, idle 35 cycles -> exactly 3 count_pulse, spaced 10 cycles;
//     mode=00; blank_*=0.
//  2. btn_mode once, btn_inc once -> busy=1 for 60 cycles with 60 count_pulse;
//     counter goes 00:00 -> 01:00; mode=01.
//  3. btn_inc during a burst, and btn_mode at burst cycle 30 -> ignored:
//     still 60 pulses; mode stays 01 afterwards.
//  4. From SET_SEC (counter at 00:59), btn_inc once -> one pulse, counter
//     01:00; blank_sec toggles every 4 cycles; blank_min=0.
//  5. btn_mode and btn_inc in the same cycle in SET_SEC -> mode=00, no pulse;
//     first RUN pulse exactly 10 cycles later.
//  6. Assert reset at burst cycle 20 -> all outputs at reset values next
//     cycle; no further pulses; mode=00 after release.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the MM:SS clock: mode encoding, internal
// sequencer states and the state-to-mode mapping.
package clock_pkg;

  localparam int unsigned SECS_PER_MIN = 60;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_SEC = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StSetMin = 2'b01,
    StBurst  = 2'b10,
    StSetSec = 2'b11
  } state_t;

  // BURST is an internal refinement of SET_MIN and reports as SET_MIN.
  function automatic mode_t state_to_mode(input state_t s);
    mode_t m;
    case (s)
      StRun:            m = RUN;
      StSetMin, StBurst: m = SET_MIN;
      StSetSec:         m = SET_SEC;
      default:          m = RUN;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-N counter with enable and synchronous clear; o_tick is high in the
// cycle the count sits at N-1 while enabled, i.e. on the wrap.
module tick_prescaler #(
  parameter int unsigned N = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] Max = W'(N - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == Max) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en & (r_cnt == Max);

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the MM:SS counter: 1 Hz ticks in RUN, single pulses in
// SET_SEC, minute-sized pulse bursts in SET_MIN, plus display blink enables.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DIV       = 100_000_000,
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter int unsigned BURST_LEN = SECS_PER_MIN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       count_pulse,
  output logic [1:0] mode,
  output logic       busy,
  output logic       blank_min,
  output logic       blank_sec
);

  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] BurstLast = BW'(BURST_LEN - 1);

  state_t        r_state;
  state_t        w_state_d;
  logic [BW-1:0] r_burst_cnt;
  logic          r_count_pulse;
  logic          w_count_pulse_d;
  logic          r_phase;

  logic w_run_tick;
  logic w_run_clr;
  logic w_blink_tick;
  logic w_blink_en;
  logic w_blink_clr;
  logic w_mode_chg;

  // Run prescaler restarts from zero whenever RUN is (re)entered.
  assign w_run_clr = (w_state_d != StRun);

  tick_prescaler #(
    .N(DIV)
  ) u_run_prescaler (
    .clk   (clk),
    .reset (reset),
    .i_en  (r_state == StRun),
    .i_clr (w_run_clr),
    .o_tick(w_run_tick)
  );

  assign w_mode_chg  = (state_to_mode(w_state_d) != state_to_mode(r_state));
  assign w_blink_en  = (r_state != StRun);
  assign w_blink_clr = w_mode_chg | (r_state == StRun);

  tick_prescaler #(
    .N(BLINK_DIV)
  ) u_blink_prescaler (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_blink_en),
    .i_clr (w_blink_clr),
    .o_tick(w_blink_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_count_pulse_d = 1'b0;
    unique case (r_state)
      StRun: begin
        w_count_pulse_d = w_run_tick;
        if (btn_mode) w_state_d = StSetMin;
      end
      StSetMin: begin
        if (btn_mode)     w_state_d = StSetSec;
        else if (btn_inc) w_state_d = StBurst;
      end
      StBurst: begin
        w_count_pulse_d = 1'b1;
        if (r_burst_cnt == BurstLast) w_state_d = StSetMin;
      end
      StSetSec: begin
        w_count_pulse_d = btn_inc & ~btn_mode;
        if (btn_mode) w_state_d = StRun;
      end
      default: w_state_d = StRun;
    endcase
  end

  // Burst count is zero outside BURST, so each burst starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_burst_cnt   <= '0;
      r_count_pulse <= 1'b0;
      r_phase       <= 1'b0;
    end else begin
      r_burst_cnt   <= (r_state == StBurst) ? r_burst_cnt + 1'b1 : '0;
      r_count_pulse <= w_count_pulse_d;
      if (w_blink_clr) begin
        r_phase <= 1'b0;
      end else if (w_blink_tick) begin
        r_phase <= ~r_phase;
      end
    end
  end

  always_comb begin
    count_pulse = r_count_pulse;
    mode        = state_to_mode(r_state);
    busy        = (r_state == StBurst);
    blank_min   = r_phase & ((r_state == StSetMin) | (r_state == StBurst));
    blank_sec   = r_phase & (r_state == StSetSec);
  end

endmodule
